clk_divider_prog: RTL and testbench

Fully synchronous, multi-channel, runtime-programmable clock divider. It replaces ripple-register division with per-channel counters in the `clk_hf` domain. Each channel produces two outputs: a one-cycle clock-enable pulse for logic that stays in `clk_hf`, and a registered, glitch-free divided clock. Divisors change only at period boundaries, so a reprogrammed channel never emits a runt period.

---
 rtl/clk_divider_prog.sv | 104 ++++++++++
 tb/tb_clk_divider_prog.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_prog.sv
// rtl/clk_divider_prog.sv - multi-channel programmable clock divider in the clk_hf domain
module clk_divider_prog #(
  parameter int CHANNELS    = 2,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 4,
  parameter int SEL_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk_hf,
  input  logic                 reset,
  input  logic [CHANNELS-1:0]  ch_enable,
  input  logic                 div_wr,
  input  logic [SEL_WIDTH-1:0] div_sel,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic [CHANNELS-1:0]  clk_en,
  output logic [CHANNELS-1:0]  clk_out,
  output logic [CHANNELS-1:0]  div_pending
);

  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] DEF_CNT = (DEFAULT_DIV > 1) ? DIV_WIDTH'(DEFAULT_DIV - 1) : '0;
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH:0]   ONE_X   = (DIV_WIDTH+1)'(1);

  logic [DIV_WIDTH-1:0] r_cnt     [CHANNELS];
  logic [DIV_WIDTH-1:0] r_div_act [CHANNELS];
  logic [DIV_WIDTH-1:0] r_div_stg [CHANNELS];
  logic [CHANNELS-1:0]  r_clk_en;
  logic [CHANNELS-1:0]  r_clk_out;
  logic [CHANNELS-1:0]  r_pending;

  logic [DIV_WIDTH-1:0] w_neff     [CHANNELS];
  logic [DIV_WIDTH-1:0] w_neff_stg [CHANNELS];
  logic [CHANNELS-1:0]  w_wrap;
  logic [CHANNELS-1:0]  w_hit;
  logic [CHANNELS-1:0]  w_hi_next;

  // Widened by one bit so cnt+1 and Neff+1 cannot overflow at the top of the range.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_neff[c]     = (r_div_act[c] == '0) ? ONE : r_div_act[c];
      w_neff_stg[c] = (r_div_stg[c] == '0) ? ONE : r_div_stg[c];
      w_wrap[c]     = (r_cnt[c] == (w_neff[c] - ONE));
      w_hit[c]      = div_wr && (div_sel == SEL_WIDTH'(c));
      w_hi_next[c]  = (({1'b0, r_cnt[c]} + ONE_X) < (({1'b0, w_neff[c]} + ONE_X) >> 1));
    end
  end

  always_ff @(posedge clk_hf) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_cnt[c]     <= DEF_CNT;
        r_div_act[c] <= DEF_DIV;
        r_div_stg[c] <= DEF_DIV;
      end
      r_clk_en  <= '0;
      r_clk_out <= '0;
      r_pending <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (!ch_enable[c]) begin
          // Parked at Neff-1 so the first enabled edge is a wrap.
          r_clk_en[c]  <= 1'b0;
          r_clk_out[c] <= 1'b0;
          if (w_hit[c]) begin
            r_div_stg[c] <= div_value;
            r_pending[c] <= 1'b1;
            r_cnt[c]     <= w_neff[c] - ONE;
          end else if (r_pending[c]) begin
            r_div_act[c] <= r_div_stg[c];
            r_pending[c] <= 1'b0;
            r_cnt[c]     <= w_neff_stg[c] - ONE;
          end else begin
            r_cnt[c]     <= w_neff[c] - ONE;
          end
        end else if (w_wrap[c]) begin
          r_cnt[c]     <= '0;
          r_clk_en[c]  <= 1'b1;
          r_clk_out[c] <= 1'b1;
          if (w_hit[c]) begin
            r_div_act[c] <= div_value;
            r_div_stg[c] <= div_value;
            r_pending[c] <= 1'b0;
          end else if (r_pending[c]) begin
            r_div_act[c] <= r_div_stg[c];
            r_pending[c] <= 1'b0;
          end
        end else begin
          r_cnt[c]     <= r_cnt[c] + ONE;
          r_clk_en[c]  <= 1'b0;
          r_clk_out[c] <= w_hi_next[c];
          if (w_hit[c]) begin
            r_div_stg[c] <= div_value;
            r_pending[c] <= 1'b1;
          end
        end
      end
    end
  end

  assign clk_en      = r_clk_en;
  assign clk_out     = r_clk_out;
  assign div_pending = r_pending;

endmodule

// File: tb/tb_clk_divider_prog.sv
// tb/tb_clk_divider_prog.sv - scoreboard bench for clk_divider_prog
module tb_clk_divider_prog;
  localparam int CH  = 2;
  localparam int DW  = 16;
  localparam int DEF = 4;
  localparam int SW  = 2;

  logic          clk_hf = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] ch_enable = '0;
  logic          div_wr = 1'b0;
  logic [SW-1:0] div_sel = '0;
  logic [DW-1:0] div_value = '0;
  logic [CH-1:0] clk_en, clk_out, div_pending;

  int errors = 0;
  int checks = 0;

  int            m_act [CH];
  int            m_stg [CH];
  int            m_ph  [CH];
  logic [CH-1:0] m_pend = '0;
  logic [CH-1:0] m_en = '0;
  logic [CH-1:0] m_out = '0;
  logic [3*CH-1:0] exp_q [$];

  clk_divider_prog #(.CHANNELS(CH), .DIV_WIDTH(DW), .DEFAULT_DIV(DEF), .SEL_WIDTH(SW)) dut (
    .clk_hf(clk_hf), .reset(reset), .ch_enable(ch_enable), .div_wr(div_wr),
    .div_sel(div_sel), .div_value(div_value), .clk_en(clk_en), .clk_out(clk_out),
    .div_pending(div_pending)
  );

  always #5 clk_hf = ~clk_hf;

  always @(posedge clk_hf) begin
    logic [3*CH-1:0] exp_v;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({div_pending, clk_out, clk_en} !== exp_v) begin
        errors++;
        $display("FAIL scoreboard t=%0t got pend/out/en=%b expected %b", $time,
                 {div_pending, clk_out, clk_en}, exp_v);
      end
    end
  end

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_edge(input logic rst, input logic [CH-1:0] en, input logic wr,
                            input logic [SW-1:0] sel, input int val);
    for (int c = 0; c < CH; c++) begin
      int n;
      bit hit;
      n = eff(m_act[c]);
      hit = wr && (int'(sel) == c);
      if (rst) begin
        m_act[c] = DEF; m_stg[c] = DEF; m_pend[c] = 1'b0;
        m_ph[c] = eff(DEF) - 1; m_en[c] = 1'b0; m_out[c] = 1'b0;
      end else if (!en[c]) begin
        m_en[c] = 1'b0; m_out[c] = 1'b0;
        if (hit) begin
          m_stg[c] = val; m_pend[c] = 1'b1; m_ph[c] = n - 1;
        end else if (m_pend[c]) begin
          m_act[c] = m_stg[c]; m_pend[c] = 1'b0; m_ph[c] = eff(m_act[c]) - 1;
        end else begin
          m_ph[c] = n - 1;
        end
      end else if (m_ph[c] == n - 1) begin
        m_ph[c] = 0; m_en[c] = 1'b1; m_out[c] = 1'b1;
        if (hit) begin
          m_act[c] = val; m_stg[c] = val; m_pend[c] = 1'b0;
        end else if (m_pend[c]) begin
          m_act[c] = m_stg[c]; m_pend[c] = 1'b0;
        end
      end else begin
        m_ph[c] = m_ph[c] + 1;
        m_en[c] = 1'b0;
        m_out[c] = (m_ph[c] < (n + 1) / 2);
        if (hit) begin
          m_stg[c] = val; m_pend[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic [CH-1:0] en, input logic wr,
                      input logic [SW-1:0] sel, input logic [DW-1:0] val);
    @(negedge clk_hf);
    reset = rst; ch_enable = en; div_wr = wr; div_sel = sel; div_value = val;
    model_edge(rst, en, wr, sel, int'(val));
    exp_q.push_back({m_pend, m_out, m_en});
    @(posedge clk_hf);
    #2;
  endtask

  task automatic idle(input int n, input logic [CH-1:0] en);
    for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, '0, '0);
  endtask

  task automatic wait_phase(input int ph, input logic [CH-1:0] en);
    int k;
    k = 0;
    while (m_ph[0] != ph && k < 20) begin
      step(1'b0, en, 1'b0, '0, '0);
      k++;
    end
    checks++;
    if (m_ph[0] != ph) begin
      errors++;
      $display("FAIL wait_phase bound expired phase=%0d required %0d", m_ph[0], ph);
    end
  endtask

  task automatic test_reset;
    step(1'b1, '0, 1'b0, '0, '0);
    step(1'b1, '0, 1'b0, '0, '0);
    checks++;
    if ({div_pending, clk_out, clk_en} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b required 0", {div_pending, clk_out, clk_en});
    end
  endtask

  task automatic test_default;
    logic [11:0] en_seq, out_seq;
    logic ch1_seen;
    en_seq = '0; out_seq = '0; ch1_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 2'b01, 1'b0, '0, '0);
      en_seq  = {en_seq[10:0], clk_en[0]};
      out_seq = {out_seq[10:0], clk_out[0]};
      ch1_seen = ch1_seen | clk_en[1] | clk_out[1];
    end
    checks++;
    if (en_seq !== 12'b100010001000) begin
      errors++; $display("FAIL default_clk_en got %b required 100010001000", en_seq);
    end
    checks++;
    if (out_seq !== 12'b110011001100) begin
      errors++; $display("FAIL default_clk_out got %b required 110011001100", out_seq);
    end
    checks++;
    if (ch1_seen !== 1'b0) begin
      errors++; $display("FAIL ch1_idle got %b required 0", ch1_seen);
    end
  endtask

  task automatic test_reprogram;
    logic [11:0] out_seq, pend_seq;
    idle(2, 2'b01);
    step(1'b0, 2'b01, 1'b1, 2'd0, 16'd5);
    checks++;
    if (div_pending[0] !== 1'b1) begin
      errors++; $display("FAIL pending_after_write got %b required 1", div_pending[0]);
    end
    out_seq = '0; pend_seq = '0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 2'b01, 1'b0, '0, '0);
      out_seq  = {out_seq[10:0], clk_out[0]};
      pend_seq = {pend_seq[10:0], div_pending[0]};
    end
    checks++;
    if (out_seq !== 12'b011100111001) begin
      errors++; $display("FAIL div5_clk_out got %b required 011100111001", out_seq);
    end
    checks++;
    if (pend_seq !== 12'b100000000000) begin
      errors++; $display("FAIL div5_pending got %b required 100000000000", pend_seq);
    end
  endtask

  task automatic test_div0_div1_div3;
    logic [5:0] en_seq, out_seq;
    logic [8:0] o3;
    step(1'b0, 2'b01, 1'b1, 2'd0, 16'd0);
    idle(8, 2'b01);
    step(1'b0, 2'b01, 1'b1, 2'd0, 16'd1);
    checks++;
    if (div_pending[0] !== 1'b0) begin
      errors++; $display("FAIL wrap_write_pending got %b required 0", div_pending[0]);
    end
    en_seq = '0; out_seq = '0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'b01, 1'b0, '0, '0);
      en_seq  = {en_seq[4:0], clk_en[0]};
      out_seq = {out_seq[4:0], clk_out[0]};
    end
    checks++;
    if ({en_seq, out_seq} !== 12'hfff) begin
      errors++; $display("FAIL div1_constant got en=%b out=%b required all ones", en_seq, out_seq);
    end
    step(1'b0, 2'b01, 1'b1, 2'd0, 16'd3);
    o3 = {8'b0, clk_out[0]};
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 2'b01, 1'b0, '0, '0);
      o3 = {o3[7:0], clk_out[0]};
    end
    checks++;
    if (o3 !== 9'b110110110) begin
      errors++; $display("FAIL div3_clk_out got %b required 110110110", o3);
    end
  endtask

  task automatic test_back_to_back;
    int first, second, idx;
    wait_phase(0, 2'b01);
    step(1'b0, 2'b01, 1'b1, 2'd0, 16'd5);
    step(1'b0, 2'b01, 1'b1, 2'd0, 16'd7);
    first = -1; second = -1; idx = 0;
    while (second < 0 && idx < 20) begin
      step(1'b0, 2'b01, 1'b0, '0, '0);
      if (clk_en[0]) begin
        if (first < 0) first = idx;
        else second = idx;
      end
      idx++;
    end
    checks++;
    if (first < 0 || second - first != 7) begin
      errors++; $display("FAIL last_write_wins gap=%0d required 7", second - first);
    end
    wait_phase(6, 2'b01);
    step(1'b0, 2'b01, 1'b1, 2'd0, 16'd2);
    checks++;
    if ({div_pending[0], clk_en[0]} !== 2'b01) begin
      errors++; $display("FAIL write_on_wrap got pend,en=%b required 01", {div_pending[0], clk_en[0]});
    end
    idle(5, 2'b01);
    step(1'b0, 2'b01, 1'b1, 2'd3, 16'd9);
    checks++;
    if (div_pending !== 2'b00) begin
      errors++; $display("FAIL bad_sel_ignored got %b required 00", div_pending);
    end
    idle(6, 2'b01);
  endtask

  task automatic test_align;
    int both;
    logic first_both;
    idle(2, 2'b00);
    step(1'b0, 2'b00, 1'b1, 2'd0, 16'd4);
    step(1'b0, 2'b00, 1'b1, 2'd1, 16'd6);
    idle(2, 2'b00);
    both = 0; first_both = 1'b0;
    for (int i = 0; i < 26; i++) begin
      step(1'b0, 2'b11, 1'b0, '0, '0);
      if (i == 0) first_both = clk_en[0] & clk_en[1];
      if (clk_en === 2'b11) both++;
    end
    checks++;
    if (first_both !== 1'b1) begin
      errors++; $display("FAIL align_first got %b required 1", first_both);
    end
    checks++;
    if (both != 3) begin
      errors++; $display("FAIL align_recur got %0d coincidences required 3", both);
    end
  endtask

  task automatic test_reset_mid;
    int first, second, idx;
    wait_phase(0, 2'b01);
    step(1'b0, 2'b01, 1'b1, 2'd0, 16'd9);
    step(1'b1, 2'b01, 1'b0, '0, '0);
    checks++;
    if ({div_pending, clk_out, clk_en} !== '0) begin
      errors++; $display("FAIL reset_mid got %b required 0", {div_pending, clk_out, clk_en});
    end
    first = -1; second = -1; idx = 0;
    while (second < 0 && idx < 20) begin
      step(1'b0, 2'b01, 1'b0, '0, '0);
      if (clk_en[0]) begin
        if (first < 0) first = idx;
        else second = idx;
      end
      idx++;
    end
    checks++;
    if (first != 0 || second != 4) begin
      errors++; $display("FAIL reset_restore pulses at %0d,%0d required 0,4", first, second);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_reprogram();
    test_div0_div1_div3();
    test_back_to_back();
    test_align();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
